lift_controller_nfloor: RTL
===========================

// Module: lift_controller_nfloor
// PURPOSE
//  Parametrised N-floor lift controller: latches hall/car requests per floor, serves them in SCAN order
//  (keep direction while requests lie ahead, then reverse), times floor travel and door dwell, and raises
//  weight/time alerts. Sits between the button/sensor front end and the motor/door drivers.
// PARAMETERS
//  NUM_FLOORS    4   number of floors, >=2; floors numbered 0..NUM_FLOORS-1
//  FLOOR_W       2   floor index width, must satisfy 2**FLOOR_W >= NUM_FLOORS
//  MOVE_CYCLES   4   clock cycles to travel one floor, >=1
//  DOOR_CYCLES   3   minimum door-open dwell in cycles, >=1
//  DOOR_TIMEOUT  10  door-open cycles after which time_alert_o asserts, > DOOR_CYCLES
// PORTS
//  clk_i           in   1           single clock, rising edge
//  rst_i           in   1           asynchronous, active-high reset
//  req_i           in   NUM_FLOORS  request pulse/level per floor
//  over_weight_i   in   1           car overloaded; sampled only while door open
//  door_block_i    in   1           door obstruction; blocks closing
//  floor_o         out  FLOOR_W     current floor
//  direction_o     out  1           1 = up, 0 = down (last/next travel direction)
//  moving_o        out  1           car in motion
//  door_open_o     out  1           door open
//  pending_o       out  NUM_FLOORS  latched unserved requests
//  arrive_o        out  1           one-cycle pulse on arrival at a requested floor
//  weight_alert_o  out  1           overweight while door open
//  time_alert_o    out  1           door held open >= DOOR_TIMEOUT cycles
// BEHAVIOUR
//  - Reset (async): state IDLE, floor_o=0, direction_o=1, pending_o=0, all other outputs 0, counters 0.
//  - Latching: req_i[k] at edge t sets pending_o[k] at t+1. Exception: k==floor_o while in IDLE or DOOR_OPEN
//    is not latched; IDLE -> DOOR_OPEN next cycle, DOOR_OPEN restarts dwell counter.
//  - States: IDLE, MOVING, DOOR_OPEN.
//  - IDLE: if pending_o has a bit ahead in direction_o -> MOVING keeping direction; else if bit behind ->
//    reverse direction_o, MOVING; else stay. moving_o=1 from the cycle after pending_o becomes nonzero.
//  - MOVING: counter counts MOVE_CYCLES; on expiry floor_o +/-1. New floor pending -> clear its bit, arrive_o=1
//    for one cycle, moving_o=0, -> DOOR_OPEN; else stay MOVING, counter restarts. Requests keep latching.
//  - Floor bounds: floor_o never below 0 or above NUM_FLOORS-1; direction_o forced 0 at top, 1 at floor 0.
//  - Request for the floor being arrived at in the same cycle: served by that arrival, not re-latched.
//  - DOOR_OPEN: door_open_o=1; dwell counter runs while over_weight_i=0 and door_block_i=0, holds otherwise.
//    Close (-> IDLE, door_open_o=0) when dwell >= DOOR_CYCLES and over_weight_i=0 and door_block_i=0.
//  - weight_alert_o = over_weight_i registered, only in DOOR_OPEN. Separate open-time counter saturates;
//    time_alert_o=1 once it reaches DOOR_TIMEOUT, held until door closes. Both alerts clear on close.
//  - over_weight_i/door_block_i ignored outside DOOR_OPEN. No closing while either is high, whatever time.
//  - Reset mid-travel: immediate return to reset values (position rehomed to floor 0 by system).
// CONFIGURATION
//  LIFT_FIRE_RECALL_EN defined: extra input fire_i (1 bit). While fire_i=1: pending_o cleared, req_i ignored,
//    car finishes current floor step, travels to floor 0 (direction_o=0), opens door, holds it open with no
//    time_alert_o until fire_i=0, then normal dwell/close. Already at 0 with door open: stays open.
//  Not defined: no fire_i port, no recall logic.
// TESTING (NUM_FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3, DOOR_TIMEOUT=10)
//  1 Reset, req_i=4'b0100 one cycle -> pending_o=0100 next cycle, moving_o=1, floor_o 1 then 2 at 4-cycle
//    steps, arrive_o pulse at floor 2, door_open_o=1 exactly 3 cycles, pending_o=0.
//  2 At floor 2 going up, pending 0001 and 1000 -> serves 3 first, then reverses, serves 0; direction_o 1 then 0.
//  3 Door open, over_weight_i=1 for 12 cycles -> weight_alert_o=1, door stays open, time_alert_o=1 at cycle 10;
//    drop weight -> close after dwell completes, both alerts 0.
//  4 req_i for current floor while door open -> dwell restarts, pending_o unchanged; at top floor direction_o=0.
//  5 rst_i asserted mid-MOVING (asynchronously, between edges) -> outputs at reset values immediately.
//  6 With LIFT_FIRE_RECALL_EN: at floor 3 pending 0100, fire_i=1 -> pending_o=0, car to 0, door held open.

Source files
------------

// File: rtl/lift_controller_nfloor.sv
// N-floor lift controller: latches floor requests, serves them in SCAN order, times travel and door dwell.
// Optional fire recall is compiled in with `define LIFT_FIRE_RECALL_EN (adds the fire_i input).
module lift_controller_nfloor #(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int MOVE_CYCLES  = 4,
    parameter int DOOR_CYCLES  = 3,
    parameter int DOOR_TIMEOUT = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_FLOORS-1:0] req_i,
    input  logic                  over_weight_i,
    input  logic                  door_block_i,
`ifdef LIFT_FIRE_RECALL_EN
    input  logic                  fire_i,
`endif
    output logic [FLOOR_W-1:0]    floor_o,
    output logic                  direction_o,
    output logic                  moving_o,
    output logic                  door_open_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  arrive_o,
    output logic                  weight_alert_o,
    output logic                  time_alert_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_DOOR   = 2'd2;

    localparam int MOVE_W  = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DWELL_W = $clog2(DOOR_CYCLES + 1);
    localparam int OPEN_W  = $clog2(DOOR_TIMEOUT + 1);

    localparam logic [MOVE_W-1:0]  MOVE_LAST  = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DOOR_CYCLES - 1);
    localparam logic [OPEN_W-1:0]  OPEN_MAX   = OPEN_W'(DOOR_TIMEOUT);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    logic [1:0]            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [MOVE_W-1:0]     move_cnt_q, move_cnt_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [OPEN_W-1:0]     open_cnt_q, open_cnt_d;
    logic                  arrive_q, arrive_d;
    logic                  weight_alert_q, weight_alert_d;
    logic                  time_alert_q, time_alert_d;

    logic                  fire;
    logic [NUM_FLOORS-1:0] req_eff;
    logic [NUM_FLOORS-1:0] cur_bit, pend_all, step_bit;
    logic [FLOOR_W-1:0]    step_floor;
    logic                  step_dir;
    logic                  hold;
    logic [OPEN_W-1:0]     open_inc;

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            if (k == int'(f)) m[k] = 1'b1;
        end
        return m;
    endfunction

    // Floors strictly above (up=1) or strictly below (up=0) floor f.
    function automatic logic [NUM_FLOORS-1:0] ahead_mask(input logic [FLOOR_W-1:0] f, input logic up);
        logic [NUM_FLOORS-1:0] m;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            m[k] = up ? (k > int'(f)) : (k < int'(f));
        end
        return m;
    endfunction

`ifdef LIFT_FIRE_RECALL_EN
    assign fire = fire_i;
`else
    assign fire = 1'b0;
`endif
    assign req_eff = fire ? '0 : req_i;

    always_comb begin
        state_d        = state_q;
        floor_d        = floor_q;
        dir_d          = dir_q;
        pending_d      = pending_q;
        move_cnt_d     = move_cnt_q;
        dwell_d        = dwell_q;
        open_cnt_d     = open_cnt_q;
        arrive_d       = 1'b0;
        weight_alert_d = 1'b0;
        time_alert_d   = 1'b0;

        cur_bit  = floor_bit(floor_q);
        pend_all = pending_q | req_eff;
        hold     = over_weight_i | door_block_i;
        open_inc = (open_cnt_q == OPEN_MAX) ? open_cnt_q : open_cnt_q + 1'b1;

        // The floor reached at the end of the current step, clamped to the shaft.
        if (dir_q && floor_q != TOP_FLOOR)
            step_floor = floor_q + 1'b1;
        else if (!dir_q && floor_q != '0)
            step_floor = floor_q - 1'b1;
        else
            step_floor = floor_q;
        step_bit = floor_bit(step_floor);
        step_dir = (step_floor == TOP_FLOOR) ? 1'b0 : ((step_floor == '0) ? 1'b1 : dir_q);

        case (state_q)
            ST_IDLE: begin
                pending_d = pend_all & ~cur_bit;
                if (fire) begin
                    dir_d = 1'b0;
                    if (floor_q == '0) begin
                        state_d    = ST_DOOR;
                        dwell_d    = '0;
                        open_cnt_d = '0;
                    end else begin
                        state_d    = ST_MOVING;
                        move_cnt_d = '0;
                    end
                end else if (|(pend_all & cur_bit)) begin
                    state_d    = ST_DOOR;
                    dwell_d    = '0;
                    open_cnt_d = '0;
                end else if (|(pending_q & ahead_mask(floor_q, dir_q))) begin
                    state_d    = ST_MOVING;
                    move_cnt_d = '0;
                end else if (|(pending_q & ahead_mask(floor_q, ~dir_q))) begin
                    state_d    = ST_MOVING;
                    dir_d      = ~dir_q;
                    move_cnt_d = '0;
                end
            end

            ST_MOVING: begin
                pending_d = pend_all;
                if (move_cnt_q != MOVE_LAST) begin
                    move_cnt_d = move_cnt_q + 1'b1;
                end else begin
                    move_cnt_d = '0;
                    floor_d    = step_floor;
                    if (fire) begin
                        dir_d = 1'b0;
                        if (step_floor == '0) begin
                            state_d    = ST_DOOR;
                            dwell_d    = '0;
                            open_cnt_d = '0;
                        end
                    end else if (|(pend_all & step_bit)) begin
                        // A request arriving on this very edge is served here, not re-latched.
                        pending_d  = pend_all & ~step_bit;
                        arrive_d   = 1'b1;
                        state_d    = ST_DOOR;
                        dwell_d    = '0;
                        open_cnt_d = '0;
                        dir_d      = step_dir;
                    end else if (|(pend_all & ahead_mask(step_floor, step_dir))) begin
                        dir_d = step_dir;
                    end else if (|(pend_all & ahead_mask(step_floor, ~step_dir))) begin
                        dir_d = ~step_dir;
                    end else begin
                        state_d = ST_IDLE;
                        dir_d   = step_dir;
                    end
                end
            end

            ST_DOOR: begin
                pending_d = pend_all & ~cur_bit;
                if (fire && floor_q == '0) begin
                    weight_alert_d = over_weight_i;
                end else if (|(req_eff & cur_bit)) begin
                    dwell_d        = '0;
                    open_cnt_d     = open_inc;
                    weight_alert_d = over_weight_i;
                    time_alert_d   = (open_inc == OPEN_MAX);
                end else if (!hold && dwell_q >= DWELL_LAST) begin
                    state_d    = ST_IDLE;
                    dwell_d    = '0;
                    open_cnt_d = '0;
                end else begin
                    if (!hold) dwell_d = dwell_q + 1'b1;
                    open_cnt_d     = open_inc;
                    weight_alert_d = over_weight_i;
                    time_alert_d   = (open_inc == OPEN_MAX);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (fire) pending_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            floor_q        <= '0;
            dir_q          <= 1'b1;
            pending_q      <= '0;
            move_cnt_q     <= '0;
            dwell_q        <= '0;
            open_cnt_q     <= '0;
            arrive_q       <= 1'b0;
            weight_alert_q <= 1'b0;
            time_alert_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            floor_q        <= floor_d;
            dir_q          <= dir_d;
            pending_q      <= pending_d;
            move_cnt_q     <= move_cnt_d;
            dwell_q        <= dwell_d;
            open_cnt_q     <= open_cnt_d;
            arrive_q       <= arrive_d;
            weight_alert_q <= weight_alert_d;
            time_alert_q   <= time_alert_d;
        end
    end

    assign floor_o        = floor_q;
    assign direction_o    = dir_q;
    assign moving_o       = (state_q == ST_MOVING);
    assign door_open_o    = (state_q == ST_DOOR);
    assign pending_o      = pending_q;
    assign arrive_o       = arrive_q;
    assign weight_alert_o = weight_alert_q;
    assign time_alert_o   = time_alert_q;

endmodule
